aes128_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core, the forward-direction counterpart of the team's iterative decryption block. It accepts one 128-bit plaintext and key per transaction and performs one full AES round per clock. Round keys are expanded on the fly, one per cycle, in step with the rounds. The registered ciphertext is presented with a one-cycle done pulse and feeds the same link/storage datapath that the decryption block reads from.

---
 rtl/aes128_encrypt_iter_if.sv | 13 +
 rtl/aes128_encrypt_iter.sv | 148 ++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_encrypt_iter_if.sv
// Request/response bundle for the iterative AES-128 encryption core.
// Byte n of every 128-bit field is bits [8n:8n+7] (FIPS-197 order).
interface aes128_encrypt_iter_if;
  logic           start;
  logic [0:127]   plaintext;
  logic [0:127]   key;
  logic           busy;
  logic           done;
  logic [0:127]   ciphertext;

  modport master (output start, plaintext, key, input busy, done, ciphertext);
  modport slave  (input start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded on the fly.
// Start accepted only when idle; ciphertext registered with a one-cycle done pulse.

// One S-box lane: GF(2^8) inverse as a^254, then the FIPS-197 affine map.
module aes128_encrypt_iter_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x63, w_x126, w_x127, w_inv;

  // Addition chain to a^254; zero maps to zero as required
  assign w_x2   = gmul(i_a, i_a);
  assign w_x3   = gmul(w_x2, i_a);
  assign w_x6   = gmul(w_x3, w_x3);
  assign w_x12  = gmul(w_x6, w_x6);
  assign w_x15  = gmul(w_x12, w_x3);
  assign w_x30  = gmul(w_x15, w_x15);
  assign w_x60  = gmul(w_x30, w_x30);
  assign w_x63  = gmul(w_x60, w_x3);
  assign w_x126 = gmul(w_x63, w_x63);
  assign w_x127 = gmul(w_x126, i_a);
  assign w_inv  = gmul(w_x127, w_x127);

  assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes128_encrypt_iter (
  input  logic                  clk,
  input  logic                  reset,
  aes128_encrypt_iter_if.slave  bus
);
  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [0:127] r_state, r_rkey, r_ct;
  logic [3:0]   r_rnd;
  logic [7:0]   r_rcon;
  logic         r_done;
  logic         w_accept, w_last;

  logic [7:0]   w_sb  [16];
  logic [7:0]   w_ksb [4];
  logic [0:31]  w_g;
  logic [0:127] w_sr, w_mc, w_nk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes128_encrypt_iter_sbox u_sb (.i_a(r_state[8*i +: 8]), .o_s(w_sb[i]));
  end

  // Key schedule taps w3 rotated left by one byte
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes128_encrypt_iter_sbox u_ksb (.i_a(r_rkey[96 + 8*((j+1)%4) +: 8]), .o_s(w_ksb[j]));
  end

  assign w_g          = {w_ksb[0] ^ r_rcon, w_ksb[1], w_ksb[2], w_ksb[3]};
  assign w_nk[0:31]   = r_rkey[0:31]   ^ w_g;
  assign w_nk[32:63]  = r_rkey[32:63]  ^ w_nk[0:31];
  assign w_nk[64:95]  = r_rkey[64:95]  ^ w_nk[32:63];
  assign w_nk[96:127] = r_rkey[96:127] ^ w_nk[64:95];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[32*c + 8*r +: 8] = w_sb[r + 4*((c+r)%4)];
    end
    assign w_mc[32*c +: 32] = mixcol(w_sr[32*c +: 32]);
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_fsm)
      IDLE: if (bus.start) begin
        w_accept  = 1'b1;
        w_fsm_nxt = RUN;
      end
      RUN: if (r_rnd == 4'd10) begin
        w_last    = 1'b1;
        w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
      r_rkey  <= '0;
      r_ct    <= '0;
      r_rnd   <= '0;
      r_rcon  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_state <= bus.plaintext ^ bus.key;
        r_rkey  <= bus.key;
        r_rnd   <= 4'd1;
        r_rcon  <= 8'h01;
      end else if (r_fsm == RUN) begin
        r_rkey <= w_nk;
        r_rcon <= xt(r_rcon);
        r_rnd  <= w_last ? 4'd0 : r_rnd + 4'd1;
        // Final round skips MixColumns and lands directly in the output register
        if (w_last) r_ct    <= w_sr ^ w_nk;
        else        r_state <= w_mc ^ w_nk;
      end
    end
  end

  assign bus.busy       = (r_fsm == RUN);
  assign bus.done       = r_done;
  assign bus.ciphertext = r_ct;
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter: byte-level AES reference model,
// random and known-answer vectors, held/pulsed start and mid-block reset.
module tb_aes128_encrypt_iter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes128_encrypt_iter_if bus();
  aes128_encrypt_iter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [0:127] ct; int acc; } exp_t;
  exp_t q[$];

  int   checks = 0, failures = 0;
  int   cyc = 0, exp_end = 0, n_acc = 0, n_done = 0;
  bit   exp_busy = 0, exp_done = 0;
  logic [7:0] sbt [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:127] k);
    logic [7:0]   rk [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   rc, tmp, a0, a1, a2, a3;
    logic [0:127] res;
    for (int i = 0; i < 16; i++) rk[i] = k[8*i +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) w[j] = rk[4*(i-1) + j];
      if (i % 4 == 0) begin
        tmp  = w[0];
        w[0] = sbt[w[1]] ^ rc;
        w[1] = sbt[w[2]];
        w[2] = sbt[w[3]];
        w[3] = sbt[tmp];
        rc   = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[4*i + j] = rk[4*(i-4) + j] ^ w[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) t[b + 4*c] = sbt[s[b + 4*((c+b)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r + i];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Acceptance tracker: decides from its own busy model which edges take a block
  initial forever begin
    bit pre;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      q.delete();
      exp_busy = 0;
      exp_done = 0;
    end else begin
      pre      = exp_busy;
      exp_done = 0;
      if (exp_busy && cyc == exp_end) begin
        exp_busy = 0;
        exp_done = 1;
      end
      if (bus.start && !pre) begin
        exp_busy = 1;
        exp_end  = cyc + 10;
        q.push_back('{aes_ref(bus.plaintext, bus.key), cyc});
        n_acc++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents done
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      chk("busy", {127'd0, bus.busy}, {127'd0, exp_busy});
      chk("done", {127'd0, bus.done}, {127'd0, exp_done});
      if (bus.done) begin
        n_done++;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got done=1 expected no block in flight");
        end else begin
          e = q.pop_front();
          chk("ciphertext", bus.ciphertext, e.ct);
          chk("latency", 128'(cyc - e.acc), 128'd10);
        end
      end
    end
  end

  task automatic run_block(input logic [0:127] pt, input logic [0:127] k, output logic [0:127] ct);
    bit ok;
    ok = 0;
    ct = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = pt; bus.key = k;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1;
        ct = bus.ciphertext;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done expected done within 15 cycles");
    end
  endtask

  task automatic kat(input string name, input logic [0:127] pt, input logic [0:127] k,
                     input logic [0:127] exp);
    logic [0:127] ct;
    run_block(pt, k, ct);
    chk(name, ct, exp);
  endtask

  initial begin
    logic [7:0]   p, qq, x;
    logic [0:127] ct, pa, ka;
    int           base_acc, base_done;

    p = 8'h01; qq = 8'h01;
    do begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b0};
      qq = qq ^ {qq[3:0], 4'b0};
      if (qq[7]) qq = qq ^ 8'h09;
      x  = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;

    bus.start = 1'b0; bus.plaintext = '0; bus.key = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {127'd0, bus.busy}, 128'd0);
    chk("reset_done", {127'd0, bus.done}, 128'd0);
    chk("reset_ct", bus.ciphertext, 128'd0);
    reset = 1'b1;

    kat("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kat("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h3925841d02dc09fbdc118597196a0b32);
    chk("rkey_r10", dut.r_rkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    kat("all_zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    for (int n = 0; n < 20; n++) begin
      run_block(rnd128(), rnd128(), ct);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // start held high with inputs changing every cycle
    @(negedge clk);
    base_acc = n_acc; base_done = n_done;
    for (int n = 0; n < 33; n++) begin
      bus.start = 1'b1; bus.plaintext = rnd128(); bus.key = rnd128();
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_accepts", 128'(n_acc - base_acc), 128'd3);
    chk("held_dones", 128'(n_done - base_done), 128'd3);

    // start pulse at E3 of a block in flight must be ignored
    pa = rnd128(); ka = rnd128();
    base_acc = n_acc;
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = pa; bus.key = ka;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.plaintext = rnd128(); bus.key = rnd128();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pulse_ct", bus.ciphertext, aes_ref(pa, ka));
    chk("pulse_accepts", 128'(n_acc - base_acc), 128'd1);

    // reset asserted at E5 of a block
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = rnd128(); bus.key = rnd128();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {127'd0, bus.busy}, 128'd0);
    chk("abort_done", {127'd0, bus.done}, 128'd0);
    chk("abort_ct", bus.ciphertext, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base_done = n_done;
    pa = rnd128(); ka = rnd128();
    kat("after_abort", pa, ka, aes_ref(pa, ka));
    repeat (3) @(negedge clk);
    chk("after_abort_dones", 128'(n_done - base_done), 128'd1);

    // reset in the same cycle as done
    run_block(rnd128(), rnd128(), ct);
    #2 reset = 1'b0;
    #1;
    chk("done_reset_done", {127'd0, bus.done}, 128'd0);
    chk("done_reset_ct", bus.ciphertext, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pa = rnd128(); ka = rnd128();
    kat("final", pa, ka, aes_ref(pa, ka));

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
